// File: rtl/score_write_ctrl_if.sv
// Score RAM write-controller bus: request side (cell writes, init) and RAM write side.
// The controller connects through the slave modport.
interface score_write_ctrl_if #(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N + 1),
  parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1),
  parameter int SW          = 10
);
  logic                    en_init;
  logic                    en_write;
  logic [BitAddr:0]        i;
  logic [BitAddr:0]        j;
  logic signed [SW-1:0]    score_in;
  logic [addr_lenght:0]    addr;
  logic signed [SW-1:0]    data;
  logic                    we;
  logic                    ack;
  logic                    err;
  logic                    busy;
  logic                    init_done;
  logic                    matrix_full;

  modport master (
    output en_init, en_write, i, j, score_in,
    input  addr, data, we, ack, err, busy, init_done, matrix_full
  );

  modport slave (
    input  en_init, en_write, i, j, score_in,
    output addr, data, we, ack, err, busy, init_done, matrix_full
  );
endinterface

// File: rtl/score_write_ctrl.sv
// Writes the (N+1)x(N+1) alignment score matrix: fills the gap-penalty border on
// en_init, then stores computed interior cells one per cycle on en_write.
module score_write_ctrl #(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N + 1),
  parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1),
  parameter int SW          = 10,
  parameter int GAP         = 2
) (
  input  logic                clk,
  input  logic                rst,
  score_write_ctrl_if.slave   bus
);

  localparam int IW = BitAddr + 1;
  localparam int AW = addr_lenght + 1;

  localparam logic [IW-1:0] LAST_K    = IW'(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(N + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT_ROW = 2'd1,
    INIT_COL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        k_q, k_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_err_q, wr_err_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic signed [SW-1:0] wr_data_q, wr_data_d;
  logic                 init_done_q, init_done_d;
  logic                 matrix_full_q, matrix_full_d;

  logic                 in_range;
  logic                 is_last_cell;
  logic [AW-1:0]        cell_addr;
  logic [SW-1:0]        penalty;

  // Interior cell (i,j) lives one row and one column past the border.
  assign in_range     = (bus.i < LAST_K) && (bus.j < LAST_K);
  assign is_last_cell = (bus.i == LAST_IDX) && (bus.j == LAST_IDX);
  assign cell_addr    = AW'(bus.j) + AW'(1) + ROW_PITCH * (AW'(bus.i) + AW'(1));
  assign penalty      = SW'(k_q) * SW'(GAP);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      wr_valid_q    <= 1'b0;
      wr_err_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      init_done_q   <= 1'b0;
      matrix_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wr_valid_q    <= wr_valid_d;
      wr_err_q      <= wr_err_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      init_done_q   <= init_done_d;
      matrix_full_q <= matrix_full_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wr_valid_d    = 1'b0;
    wr_err_d      = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = '0;
    init_done_d   = init_done_q;
    matrix_full_d = matrix_full_q;

    case (state_q)
      IDLE: begin
        // A simultaneous en_write is dropped: initialization has priority.
        if (bus.en_init) begin
          state_d       = INIT_ROW;
          k_d           = '0;
          init_done_d   = 1'b0;
          matrix_full_d = 1'b0;
        end else if (bus.en_write) begin
          if (in_range) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = cell_addr;
            wr_data_d  = bus.score_in;
            if (is_last_cell) begin
              matrix_full_d = 1'b1;
            end
          end else begin
            wr_err_d = 1'b1;
          end
        end
      end

      INIT_ROW: begin
        if (k_q == LAST_K) begin
          state_d = INIT_COL;
          k_d     = IW'(1);
        end else begin
          k_d = k_q + IW'(1);
        end
      end

      INIT_COL: begin
        if (k_q == LAST_K) begin
          state_d     = IDLE;
          k_d         = '0;
          init_done_d = 1'b1;
        end else begin
          k_d = k_q + IW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Outputs decode registered state only; a cell write's address/data are zero
  // whenever it is not valid, so IDLE can forward them unconditionally.
  always_comb begin
    bus.addr = '0;
    bus.data = '0;
    bus.we   = 1'b0;
    bus.ack  = 1'b0;
    bus.err  = 1'b0;

    case (state_q)
      INIT_ROW: begin
        bus.addr = AW'(k_q);
        bus.data = -penalty;
        bus.we   = 1'b1;
      end

      INIT_COL: begin
        bus.addr = ROW_PITCH * AW'(k_q);
        bus.data = -penalty;
        bus.we   = 1'b1;
      end

      default: begin
        bus.addr = wr_addr_q;
        bus.data = wr_data_q;
        bus.we   = wr_valid_q;
        bus.ack  = wr_valid_q;
        bus.err  = wr_err_q;
      end
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.init_done   = init_done_q;
  assign bus.matrix_full = matrix_full_q;

endmodule

// File: tb/tb_score_write_ctrl.sv
// Scoreboard bench for score_write_ctrl (N=4, GAP=2, SW=10): stimulus pushes expected
// RAM writes/errors; a negedge monitor pops and compares whenever we or err is seen.
module tb_score_write_ctrl;

  localparam int N   = 4;
  localparam int SW  = 10;
  localparam int GAP = 2;
  localparam int AW  = $clog2(((N + 1) * (N + 1)) - 1) + 1;
  localparam int OW  = AW + SW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q[$];

  score_write_ctrl_if #(.N(N), .SW(SW)) bus ();

  score_write_ctrl #(.N(N), .SW(SW), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [OW-1:0] mk(input int a, input int d, input logic we,
                                       input logic ack, input logic err);
    logic [AW-1:0] av;
    logic [SW-1:0] dv;
    av = AW'(a);
    dv = SW'(d);
    return {av, dv, we, ack, err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Border image for N=4, GAP=2: row 0 then column 0.
  int init_addr[9] = '{0, 1, 2, 3, 4, 5, 10, 15, 20};
  int init_data[9] = '{0, -2, -4, -6, -8, -2, -4, -6, -8};

  task automatic push_init();
    for (int n = 0; n < 9; n++) exp_q.push_back(mk(init_addr[n], init_data[n], 1'b1, 1'b0, 1'b0));
  endtask

  task automatic set_write(input logic en, input int ii, input int jj, input int s);
    bus.en_write = en;
    bus.i        = 4'(ii);
    bus.j        = 4'(jj);
    bus.score_in = SW'(s);
  endtask

  // Monitor: any write or error must match the head of the scoreboard; quiet
  // cycles must show all-zero write outputs.
  always @(negedge clk) begin
    logic [OW-1:0] act;
    act = {bus.addr, bus.data, bus.we, bus.ack, bus.err};
    if (bus.we || bus.err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(act), 32'(mk(0, 0, 1'b0, 1'b0, 1'b0)));
      end else begin
        check("ram_write", 32'(act), 32'(exp_q.pop_front()));
      end
    end else begin
      check("quiet_outputs", 32'(act), 32'(mk(0, 0, 1'b0, 1'b0, 1'b0)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bus.en_init = 1'b0;
    set_write(1'b0, 0, 0, 0);

    // Reset state while rst held.
    #3;
    check("rst_we",          32'(bus.we),          32'd0);
    check("rst_init_done",   32'(bus.init_done),   32'd0);
    check("rst_matrix_full", 32'(bus.matrix_full), 32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Border initialization: 9 writes, then init_done and idle.
    push_init();
    bus.en_init = 1'b1;
    cyc();
    bus.en_init = 1'b0;
    check("init_busy", 32'(bus.busy), 32'd1);
    repeat (9) cyc();
    check("init_done", 32'(bus.init_done), 32'd1);
    check("init_idle", 32'(bus.busy),      32'd0);
    check("init_drained", 32'(exp_q.size()), 32'd0);

    // Single write (1,2) -> addr 13.
    exp_q.push_back(mk(13, 7, 1'b1, 1'b1, 1'b0));
    set_write(1'b1, 1, 2, 7);
    cyc();
    set_write(1'b0, 0, 0, 0);
    cyc();

    // Back-to-back writes, last cell sets matrix_full with its ack.
    exp_q.push_back(mk(6, -3, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(7, 5, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(24, 12, 1'b1, 1'b1, 1'b0));
    set_write(1'b1, 0, 0, -3);
    cyc();
    set_write(1'b1, 0, 1, 5);
    cyc();
    set_write(1'b1, 3, 3, 12);
    check("full_before_last", 32'(bus.matrix_full), 32'd0);
    cyc();
    set_write(1'b0, 0, 0, 0);
    check("full_with_ack", 32'(bus.ack),         32'd1);
    check("full_set",      32'(bus.matrix_full), 32'd1);
    cyc();

    // Out-of-range indices raise err only.
    exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(0, 0, 1'b0, 1'b0, 1'b1));
    set_write(1'b1, 4, 0, 9);
    cyc();
    set_write(1'b1, 3, 4, 9);
    cyc();
    set_write(1'b0, 0, 0, 0);
    cyc();

    // en_write with en_init, held through init, plus en_init while busy.
    push_init();
    bus.en_init = 1'b1;
    set_write(1'b1, 0, 0, 1);
    cyc();
    bus.en_init = 1'b0;
    check("reinit_done_clr", 32'(bus.init_done),   32'd0);
    check("reinit_full_clr", 32'(bus.matrix_full), 32'd0);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 3) bus.en_init = 1'b1;
      if (c == 4) bus.en_init = 1'b0;
    end
    set_write(1'b0, 0, 0, 0);
    cyc();
    check("reinit_done", 32'(bus.init_done), 32'd1);
    check("reinit_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) cyc();

    // Reset during the 4th init write aborts immediately.
    for (int n = 0; n < 3; n++) exp_q.push_back(mk(init_addr[n], init_data[n], 1'b1, 1'b0, 1'b0));
    bus.en_init = 1'b1;
    cyc();
    bus.en_init = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    check("abort_we",        32'(bus.we),        32'd0);
    check("abort_init_done", 32'(bus.init_done), 32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_addr",      32'(bus.addr),      32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    repeat (5) cyc();
    check("abort_drained", 32'(exp_q.size()), 32'd0);

    // Normal writes resume after reset: (2,0) -> addr 16.
    exp_q.push_back(mk(16, -5, 1'b1, 1'b1, 1'b0));
    set_write(1'b1, 2, 0, -5);
    cyc();
    set_write(1'b0, 0, 0, 0);
    repeat (2) cyc();
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
